// File: rtl/uart_tx_buffered_if.sv
// Write-side handshake bundle for uart_tx_buffered.
// master drives i_TX_DV/i_TX_Byte, slave returns o_TX_Ready.
interface uart_tx_buffered_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_TX_DV;
  logic [DATA_BITS-1:0] i_TX_Byte;
  logic                 o_TX_Ready;

  modport master (
    output i_TX_DV,
    output i_TX_Byte,
    input  o_TX_Ready
  );

  modport slave (
    input  i_TX_DV,
    input  i_TX_Byte,
    output o_TX_Ready
  );
endinterface

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter: configurable data/parity/stop bits,
// back-to-back frames with no idle gap between queued bytes.
// Ports: i_Clock, i_Reset (sync, active high), wr (write handshake
// slave: i_TX_DV, i_TX_Byte, o_TX_Ready), o_TX_Serial, o_TX_Active,
// o_TX_Done, o_FIFO_Count. Optional macro UART_TX_BREAK_EN adds i_Break.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
`ifdef UART_TX_BREAK_EN
  input  logic                          i_Break,
`endif
  uart_tx_buffered_if.slave             wr,
  output logic                          o_TX_Serial,
  output logic                          o_TX_Active,
  output logic                          o_TX_Done,
  output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
`ifdef UART_TX_BREAK_EN
    S_BRK   = 3'd5,
    S_MARK  = 3'd6,
`endif
    S_STOP  = 3'd4
  } state_t;

  state_t               state, state_n;
  logic [15:0]          cnt, cnt_n;
  logic [IW-1:0]        bidx, bidx_n, nxt;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 serial, serial_n;
  logic                 active, active_n;
  logic                 done, done_n;
  logic                 pop;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wptr, rptr;
  logic [AW:0]          count;
  logic                 full, push;
  logic                 avail_q;
  logic                 has_data, can_pop, brk;
  logic                 last, par_bit;

  // Full/ready come from the registered count only.
  assign full = (count == (AW+1)'(FIFO_DEPTH));
  assign push = wr.i_TX_DV & ~full;
  assign wr.o_TX_Ready = ~full;

  // avail_q lags the count by one edge, so a byte written into an
  // idle empty queue starts on the second edge after the write.
  assign has_data = avail_q & (count != '0);

`ifdef UART_TX_BREAK_EN
  assign brk = i_Break;
`else
  assign brk = 1'b0;
`endif

  assign can_pop = has_data & ~brk;
  assign last    = (cnt == 16'(CLKS_PER_BIT - 1));
  assign par_bit = (PARITY == 1) ? ~^shreg : ^shreg;
  assign nxt     = bidx + IW'(1);

  always_ff @(posedge i_Clock) begin
    if (push) mem[wptr] <= wr.i_TX_Byte;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      avail_q <= 1'b0;
    end else begin
      avail_q <= (count != '0);
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      bidx   <= '0;
      shreg  <= '0;
      serial <= 1'b1;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      bidx   <= bidx_n;
      shreg  <= shreg_n;
      serial <= serial_n;
      active <= active_n;
      done   <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 16'd1;
    bidx_n   = bidx;
    shreg_n  = shreg;
    serial_n = serial;
    active_n = active;
    done_n   = 1'b0;
    pop      = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_n    = '0;
        bidx_n   = '0;
        serial_n = 1'b1;
        active_n = 1'b0;
        if (can_pop) begin
          pop      = 1'b1;
          shreg_n  = mem[rptr];
          serial_n = 1'b0;
          active_n = 1'b1;
          state_n  = S_START;
        end
`ifdef UART_TX_BREAK_EN
        else if (brk) begin
          serial_n = 1'b0;
          state_n  = S_BRK;
        end
`endif
      end
      S_START: begin
        if (last) begin
          cnt_n    = '0;
          bidx_n   = '0;
          serial_n = shreg[0];
          state_n  = S_DATA;
        end
      end
      S_DATA: begin
        if (last) begin
          cnt_n = '0;
          if (bidx == IW'(DATA_BITS - 1)) begin
            bidx_n = '0;
            if (PARITY != 0) begin
              serial_n = par_bit;
              state_n  = S_PAR;
            end else begin
              serial_n = 1'b1;
              state_n  = S_STOP;
            end
          end else begin
            bidx_n   = nxt;
            serial_n = shreg[nxt];
          end
        end
      end
      S_PAR: begin
        if (last) begin
          cnt_n    = '0;
          bidx_n   = '0;
          serial_n = 1'b1;
          state_n  = S_STOP;
        end
      end
      S_STOP: begin
        serial_n = 1'b1;
        if (last) begin
          cnt_n = '0;
          if (bidx == IW'(STOP_BITS - 1)) begin
            bidx_n = '0;
            done_n = 1'b1;
            if (can_pop) begin
              // Next start bit on the same edge: no idle gap.
              pop      = 1'b1;
              shreg_n  = mem[rptr];
              serial_n = 1'b0;
              state_n  = S_START;
            end else begin
              active_n = 1'b0;
              state_n  = S_IDLE;
            end
          end else begin
            bidx_n = nxt;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BRK: begin
        cnt_n    = '0;
        serial_n = 1'b0;
        active_n = 1'b0;
        if (!brk) begin
          serial_n = 1'b1;
          state_n  = S_MARK;
        end
      end
      // One full mark bit after a break before the next start bit.
      S_MARK: begin
        serial_n = 1'b1;
        if (last) begin
          cnt_n   = '0;
          state_n = S_IDLE;
        end
      end
`endif
      default: begin
        cnt_n    = '0;
        bidx_n   = '0;
        serial_n = 1'b1;
        active_n = 1'b0;
        state_n  = S_IDLE;
      end
    endcase
  end

  assign o_TX_Serial  = serial;
  assign o_TX_Active  = active;
  assign o_TX_Done    = done;
  assign o_FIFO_Count = count;

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
Parametrised successor to the single-byte N,8,1 UART transmitter. Adds a configurable frame format (data width, parity, stop bits) and an internal FIFO with a valid/ready write handshake. Queued bytes are sent back-to-back with no idle gap between frames. Sits between the host/terminal logic and the serial TX pin, in the same clock domain as the rest of the terminal datapath.

Parameters:
CLKS_PER_BIT, 217, clocks per serial bit (f_clk / baud); legal range 2..65535
DATA_BITS, 8, data bits per frame; legal range 5..9, sent LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2 stop bits
FIFO_DEPTH, 4, FIFO entries; power of two, 2..256

Ports:
i_Clock  in  1  system clock; all logic on its rising edge
i_Reset  in  1  synchronous, active-high reset
i_TX_DV  in  1  write strobe; a byte is accepted when i_TX_DV and o_TX_Ready are both high
i_TX_Byte  in  DATA_BITS  data to enqueue
o_TX_Ready  out  1  high when FIFO not full
o_TX_Serial  out  1  serial line, registered; idle high
o_TX_Active  out  1  high from the first start-bit cycle through the last stop-bit cycle of a frame
o_TX_Done  out  1  one-cycle pulse per completed frame
o_FIFO_Count  out  clog2(FIFO_DEPTH)+1  number of queued bytes, excluding the byte in flight

Behaviour:
- Reset (i_Reset high at a clock edge): state IDLE, FIFO emptied, o_TX_Serial=1, o_TX_Ready=1, o_TX_Active=0, o_TX_Done=0, o_FIFO_Count=0.
- Reset mid-frame aborts the frame; the line is high on the next edge and the FIFO contents are lost.
- Write: push occurs on an edge with i_TX_DV=1 and o_TX_Ready=1. When full, the write is ignored and no error flag is raised.
- Full/ready are computed from the registered count, so a write while full is dropped even if a pop occurs on the same edge.
- Push and pop on the same edge: the count is unchanged.
- State machine: IDLE -> START -> DATA -> [PARITY if PARITY!=0] -> STOP -> IDLE, or -> START if the FIFO is non-empty.
- IDLE: if the FIFO is non-empty at the edge, pop into the shift register, drive o_TX_Serial=0, set o_TX_Active=1, go to START.
- A byte written into an empty idle FIFO reaches the line 2 edges after the write edge.
- Every bit, including each stop bit, is held exactly CLKS_PER_BIT cycles. The bit counter is 16 bits wide and resets to 0 on every bit boundary.
- DATA: bits 0..DATA_BITS-1, LSB first.
- PARITY: odd means the XOR of data and parity bit = 1; even means it = 0.
- STOP: line high for STOP_BITS*CLKS_PER_BIT cycles.
- At the final stop-bit edge:
  - o_TX_Done=1 for exactly one cycle.
  - If the FIFO is non-empty: pop and drive the start bit on that same edge. o_TX_Active stays 1 and there is zero idle time between frames.
  - Otherwise: o_TX_Active=0 and return to IDLE.
- Frame period = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Illegal state encodings return to IDLE with the line high.

Optional Feature:
UART_TX_BREAK_EN
- Defined: adds input i_Break (1 bit).
- While i_Break=1 and state is IDLE, o_TX_Serial=0 and no pops occur. A frame in progress completes first.
- Writes are still accepted during break. Transmission resumes on the first edge after i_Break falls, with o_TX_Serial=1 for at least one bit period before the next start bit.
- Not defined: the port is absent and the line idles high.

Test Plan:
- Defaults, CLKS_PER_BIT=4, write 0x55 -> line 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; start bit 2 edges after write; o_TX_Done one pulse at edge 40 after the start edge.
- Write 0xA3, 0x0F, 0xFF on consecutive cycles -> three frames back-to-back with no idle cycle; o_FIFO_Count goes 1,2 then counts down; three o_TX_Done pulses 40 cycles apart.
- FIFO_DEPTH=4, six writes in consecutive cycles while idle -> first pops immediately, next four queue, o_TX_Ready=0, sixth dropped; exactly 5 frames transmitted.
- PARITY=2, DATA_BITS=7, STOP_BITS=2, write 0x07 -> parity bit 1, two stop bits; frame = 11*CLKS_PER_BIT cycles.
- Reset asserted during the 3rd data bit with 2 bytes queued -> next edge: line=1, o_TX_Active=0, o_FIFO_Count=0; no further frames.
- UART_TX_BREAK_EN defined, i_Break=1 during a frame -> frame completes, then line held 0; after release, line high for ≥1 bit period, then the queued byte is sent.
